// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver (8N1, optional even parity) feeding a small byte FIFO.
// Latency: a byte appears on rx_data/rx_status one sysclk after its stop-bit sample edge.
// Backpressure: none on the serial line; a byte arriving at a full FIFO without a same-cycle rd_en is dropped and flags overrun.
//
// Ports:
//   sysclk, reset (async, active-low)       clock and reset
//   sam_tick                                one-cycle strobe at OVERSAMPLE x baud
//   uart_rxd                                raw serial input, idle high, LSB first
//   rd_en                                   pop the FIFO head (ignored while empty)
//   err_clr                                 clear sticky flags (a same-edge set wins)
//   rx_data, rx_status                      FIFO head byte and non-empty indication
//   overrun, frame_err, parity_err          sticky error flags
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
//   Without it the frame is 10 bits and parity_err is tied low.

// Generic single-clock FIFO with valid/ready ports. A write into a full FIFO is
// accepted when a read fires on the same edge (pop-then-push), so occupancy holds.
module uart_rx_fifo_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_rdy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_dat,
    input  logic          rd_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_fire;
    logic          rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld & rd_rdy;
    assign wr_rdy  = (count != CNT_FULL) | rd_fire;
    assign wr_fire = wr_vld & wr_rdy;

    // Head is combinational from storage; an empty FIFO presents zero.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_dat;
    end
endmodule

module uart_rx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       sam_tick,
    input  logic       uart_rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_vld;
    logic          push_rdy;
    logic          rxd_m;
    logic          rxd_s;
    logic          stop_smp;
    logic          par_ok;

    // Two-flop synchronizer; reset to the idle (high) level so a line that is
    // already low at release is seen as a fresh falling edge, never mid-frame.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    assign stop_smp = sam_tick && (state == STOP) && (cnt == CNT_END);

`ifdef UART_RX_PARITY_EN
    logic par_smp;
    logic par_bad;

    assign par_smp = sam_tick && (state == PARITY) && (cnt == CNT_END);
    assign par_ok  = ~par_bad;
`else
    assign par_ok  = 1'b1;
`endif

    // Receive FSM. The START check lands mid start bit; from there every
    // OVERSAMPLE ticks lands mid-bit for data, parity and stop.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            push_vld <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            push_vld <= 1'b0;
            if (sam_tick) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt     <= '0;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                            // A line back high by mid start bit is a glitch.
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_END) begin
                            cnt     <= '0;
                            shreg   <= {rxd_s, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == CNT_END) begin
                            cnt     <= '0;
                            // Even parity: data bits plus parity bit XOR to zero.
                            par_bad <= (^shreg) ^ rxd_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == CNT_END) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (rxd_s && par_ok) push_vld <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // shreg is not touched again until the next frame's first data sample,
    // so it still holds the byte on the cycle push_vld is high.
    uart_rx_fifo_buf #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk    (sysclk),
        .rst_n  (reset),
        .wr_vld (push_vld),
        .wr_dat (shreg),
        .wr_rdy (push_rdy),
        .rd_vld (rx_status),
        .rd_dat (rx_data),
        .rd_rdy (rd_en)
    );

    // Sticky flags: a set event on the same edge as err_clr keeps the flag high.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (push_vld & ~push_rdy) | (overrun & ~err_clr);
            frame_err <= (stop_smp & ~rxd_s) | (frame_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (par_smp & ((^shreg) ^ rxd_s)) | (parity_err & ~err_clr);
        end
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic       sam_tick;
    logic       uart_rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int n_cmp = 0;
    int n_err = 0;
    int tick_div;

    // Reference model: ordered list of bytes the receiver should hold, plus flags.
    logic [7:0] exp_q[$];
    logic       exp_ovr, exp_frm, exp_par;
    // Observations captured by send_frame around the stop sample.
    logic       st_after_sample, st_after_push;
    logic [7:0] dat_after_push, rd_cap, rd_exp;
    logic       rd_exp_vld;

    uart_rx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .sam_tick   (sam_tick),
        .uart_rxd   (uart_rxd),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_status  (rx_status),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        sam_tick = 1'b0;
        tick_div = 0;
        forever begin
            @(negedge sysclk);
            tick_div = (tick_div + 1) % TICK_DIV;
            sam_tick = (tick_div == 0);
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // Returns just after the posedge carrying the n-th next tick.
    task automatic wait_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            while (!sam_tick) @(posedge sysclk);
        end
    endtask

    // Sends one frame with bit edges aligned to ticks, then 16 idle ticks.
    // With the line falling after tick X, the receiver samples its stop bit on
    // tick X+153 (+16 with parity); the result is pushed on the following edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                              input logic rd_at_push, input logic clr_at_sample);
        wait_tick(1);
        @(negedge sysclk); uart_rxd = 1'b0; wait_tick(OS);
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk); uart_rxd = d[i]; wait_tick(OS);
        end
`ifdef UART_RX_PARITY_EN
        @(negedge sysclk); uart_rxd = (^d) ^ bad_par; wait_tick(OS);
`endif
        @(negedge sysclk); uart_rxd = stop; wait_tick(OS / 2);
        if (clr_at_sample) begin
            @(negedge sysclk); err_clr = 1'b1;
        end
        wait_tick(1);
        @(negedge sysclk);
        err_clr         = 1'b0;
        st_after_sample = rx_status;
        rd_cap          = rx_data;
        rd_en           = rd_at_push;
        @(negedge sysclk);
        rd_en           = 1'b0;
        st_after_push   = rx_status;
        dat_after_push  = rx_data;
        wait_tick(OS / 2 - 1);
        @(negedge sysclk); uart_rxd = 1'b1; wait_tick(OS);
        // Model: parity flagged first, then any clear, then stop/pop/push.
        if (PAR_EN && bad_par) exp_par = 1'b1;
        if (clr_at_sample) begin
            exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
        end
        if (!stop) exp_frm = 1'b1;
        rd_exp_vld = 1'b0;
        if (rd_at_push && exp_q.size() > 0) begin
            rd_exp     = exp_q.pop_front();
            rd_exp_vld = 1'b1;
        end
        if (stop && !(PAR_EN && bad_par)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovr = 1'b1;
        end
    endtask

    task automatic read_one(output logic [7:0] d, output logic st);
        @(negedge sysclk); d = rx_data; st = rx_status; rd_en = 1'b1;
        @(negedge sysclk); rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge sysclk); err_clr = 1'b1;
        @(negedge sysclk); err_clr = 1'b0;
        exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
    endtask

    // Reads every byte the model expects in order, then one read on empty.
    task automatic test_drain(input string tag);
        logic [7:0] d, e;
        logic       st;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_one(d, st);
            n_cmp++;
            if (st !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL %s_read: status=%b data=%h, required status=1 data=%h", tag, st, d, e);
            end
        end
        read_one(d, st);
        @(negedge sysclk);
        n_cmp++;
        if (st !== 1'b0 || rx_status !== 1'b0 ||
            {overrun, frame_err, parity_err} !== {exp_ovr, exp_frm, exp_par}) begin
            n_err++;
            $display("FAIL %s_empty: status=%b/%b flags=%b, required status=0 flags=%b",
                     tag, st, rx_status, {overrun, frame_err, parity_err}, {exp_ovr, exp_frm, exp_par});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; uart_rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
        repeat (3) @(negedge sysclk);
        n_cmp++;
        if ({rx_status, rx_data, overrun, frame_err, parity_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: status=%b data=%h flags=%b, required all zero",
                     rx_status, rx_data, {overrun, frame_err, parity_err});
        end
        reset = 1'b1;
        wait_tick(3 * OS);
        @(negedge sysclk);
        n_cmp++;
        if ({rx_status, overrun, frame_err, parity_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: status=%b flags=%b, required 0/000",
                     rx_status, {overrun, frame_err, parity_err});
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (st_after_sample !== 1'b0) begin
            n_err++;
            $display("FAIL basic_before_push: status=%b, required 0", st_after_sample);
        end
        n_cmp++;
        if (st_after_push !== 1'b1 || dat_after_push !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_latency: status=%b data=%h, required status=1 data=a5",
                     st_after_push, dat_after_push);
        end
        test_drain("basic");
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (overrun !== 1'b1 || exp_ovr !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: overrun=%b, required 1", overrun);
        end
        test_drain("overrun");
        pulse_clr();
        @(negedge sysclk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (frame_err !== 1'b1 || rx_status !== 1'b0) begin
            n_err++;
            $display("FAIL frame_err_set: frame_err=%b status=%b, required 1/0", frame_err, rx_status);
        end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        test_drain("frame_recover");
        // Clear held across a new framing error on the same edge: the set wins.
        send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (frame_err !== exp_frm) begin
            n_err++;
            $display("FAIL frame_set_wins: frame_err=%b, required %b", frame_err, exp_frm);
        end
        pulse_clr();
        @(negedge sysclk);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL frame_clear: frame_err=%b, required 0", frame_err);
        end
    endtask

    task automatic test_glitch();
        wait_tick(1);
        @(negedge sysclk); uart_rxd = 1'b0; wait_tick(4);
        @(negedge sysclk); uart_rxd = 1'b1; wait_tick(2 * OS);
        @(negedge sysclk);
        n_cmp++;
        if ({rx_status, overrun, frame_err, parity_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch_reject: status=%b flags=%b, required 0/000",
                     rx_status, {overrun, frame_err, parity_err});
        end
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        test_drain("glitch_after");
    endtask

    task automatic test_full_rd();
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (rd_exp_vld !== 1'b1 || rd_cap !== rd_exp) begin
            n_err++;
            $display("FAIL full_rd_head: data=%h, required %h", rd_cap, rd_exp);
        end
        n_cmp++;
        if (overrun !== 1'b0 || st_after_push !== 1'b1) begin
            n_err++;
            $display("FAIL full_rd_no_overrun: overrun=%b status=%b, required 0/1", overrun, st_after_push);
        end
        test_drain("full_rd");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h6E, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_tick(1);
        @(negedge sysclk); uart_rxd = 1'b0; wait_tick(OS);
        @(negedge sysclk); uart_rxd = 1'b1; wait_tick(4);
        @(negedge sysclk); reset = 1'b0;
        #1;
        n_cmp++;
        if ({rx_status, rx_data, overrun, frame_err, parity_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async: status=%b data=%h flags=%b, required all zero",
                     rx_status, rx_data, {overrun, frame_err, parity_err});
        end
        exp_q.delete();
        exp_ovr = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
        @(negedge sysclk); reset = 1'b1;
        wait_tick(12 * OS);
        @(negedge sysclk);
        n_cmp++;
        if ({rx_status, overrun, frame_err, parity_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_partial_dropped: status=%b flags=%b, required 0/000",
                     rx_status, {overrun, frame_err, parity_err});
        end
        send_frame(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0);
        test_drain("reset_resume");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (parity_err !== 1'b1 || rx_status !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_set: parity_err=%b status=%b frame_err=%b, required 1/0/0",
                     parity_err, rx_status, frame_err);
        end
        pulse_clr();
        @(negedge sysclk);
        n_cmp++;
        if (parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clear: parity_err=%b, required 0", parity_err);
        end
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        test_drain("parity_good");
    endtask
`endif

    task automatic test_random();
        logic [7:0] d, e;
        logic       st, stop, bad_par, rd_at_push;
        int         nrd;
        for (int it = 0; it < 12; it++) begin
            d          = 8'($urandom);
            stop       = ($urandom_range(0, 5) != 0);
            bad_par    = PAR_EN && ($urandom_range(0, 4) == 0);
            rd_at_push = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, bad_par, rd_at_push, 1'b0);
            if (rd_exp_vld) begin
                n_cmp++;
                if (rd_cap !== rd_exp) begin
                    n_err++;
                    $display("FAIL rand_rd_at_push[%0d]: data=%h, required %h", it, rd_cap, rd_exp);
                end
            end
            @(negedge sysclk);
            n_cmp++;
            if (rx_status !== (exp_q.size() > 0) ||
                {overrun, frame_err, parity_err} !== {exp_ovr, exp_frm, exp_par}) begin
                n_err++;
                $display("FAIL rand_state[%0d]: status=%b flags=%b, required status=%b flags=%b",
                         it, rx_status, {overrun, frame_err, parity_err},
                         (exp_q.size() > 0), {exp_ovr, exp_frm, exp_par});
            end
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) begin
                read_one(d, st);
                n_cmp++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (st !== 1'b1 || d !== e) begin
                        n_err++;
                        $display("FAIL rand_read[%0d]: status=%b data=%h, required status=1 data=%h",
                                 it, st, d, e);
                    end
                end else if (st !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_read_empty[%0d]: status=%b, required 0", it, st);
                end
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        test_drain("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_full_rd();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, 16, sam_tick strobes per bit period (power of two, >= 8).
REQ-002 SHALL provide parameter FIFO_DEPTH, 4, received-byte buffer entries (power of two, 2..16).
REQ-003 SHALL have port sysclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sam_tick  input  1  one-sysclk strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high, 8 data bits LSB first.
REQ-007 SHALL have port rd_en  input  1  pop FIFO head, one entry per asserted cycle.
REQ-008 SHALL have port err_clr  input  1  clears all sticky error flags.
REQ-009 SHALL have port rx_data  output  8  FIFO head byte, valid while rx_status=1.
REQ-010 SHALL have port rx_status  output  1  FIFO non-empty.
REQ-011 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-012 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-013 SHALL have port parity_err  output  1  sticky: parity mismatch (constant 0 when parity compiled out).

Function
REQ-014 SHALL pass uart_rxd through a 2-flop synchronizer (rxd_s) before any use.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; bit-phase counter cnt advances only on sam_tick.
REQ-016 IDLE: on sam_tick with rxd_s=0 SHALL go START, cnt=0.
REQ-017 START: at cnt=OVERSAMPLE/2-1, rxd_s=0 -> DATA with cnt=0, bit index 0; rxd_s=1 -> IDLE (glitch rejected, nothing pushed).
REQ-018 DATA: SHALL sample rxd_s at cnt=OVERSAMPLE-1 into shift register LSB first; after bit 7 -> PARITY if compiled in, else STOP.
REQ-019 STOP: at cnt=OVERSAMPLE-1, rxd_s=1 -> push byte; rxd_s=0 -> set frame_err, discard byte; both -> IDLE.
REQ-020 Push SHALL make rx_status=1 on the sysclk edge following the stop-sample edge (1-cycle latency).
REQ-021 rx_data SHALL show the oldest entry with no read latency; rd_en advances head on same edge.
REQ-022 rd_en while empty SHALL be ignored (pointers, flags unchanged).
REQ-023 Push while full with no rd_en SHALL drop the new byte and set overrun; stored data untouched.
REQ-024 Push and rd_en on same cycle while full SHALL pop then push: no overrun, count unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-026 err_clr SHALL clear sticky flags next edge; simultaneous set event SHALL win (flag stays 1).
REQ-027 A framing error SHALL NOT hang the FSM; a low line after STOP restarts detection from IDLE.

Reset
REQ-028 reset=0 SHALL immediately force: FSM IDLE, cnt 0, synchronizer flops 1, FIFO empty, rx_status 0, rx_data 0x00, overrun/frame_err/parity_err 0.
REQ-029 Reset mid-frame SHALL abandon the partial byte; after release reception resumes only at the next falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit at cnt=OVERSAMPLE-1; mismatch sets parity_err and discards byte, then STOP still checked.
REQ-031 Macro UART_RX_PARITY_EN undefined: no PARITY state, DATA -> STOP directly, parity_err tied 0, frame is 10 bits.

Verification
REQ-032 Reset, send 0xA5 at 16x ticks, stop=1 -> rx_status=1, rx_data=0xA5 one cycle after stop sample; rd_en -> rx_status=0.
REQ-033 Send 5 bytes 0x01..0x05 without reads (depth 4) -> overrun=1, reads return 0x01..0x04 then empty.
REQ-034 Send 0x3C with stop bit 0 -> frame_err=1, rx_status stays 0; next 0x55 received correctly.
REQ-035 Low pulse of 4 ticks on idle line -> FSM back to IDLE, nothing pushed, no error flags.
REQ-036 FIFO full, final stop sample coincides with rd_en -> overrun=0, occupancy remains 4, order preserved.
REQ-037 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> parity_err=1, byte discarded; err_clr -> 0.
